// File: rtl/img_stream_pkg.sv
// Purpose: shared types and width helper for the image ROM streamer.
//   state_e : fetch FSM states
//   cnt_w() : bits needed to hold 0..n-1 (minimum 1)
package img_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int unsigned UFLOW_W = 16;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/img_rom_streamer_pix_fifo.sv
// Purpose: synchronous pixel FIFO with flush, occupancy count and flags.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_flush            synchronous clear of both pointers
//   i_push, i_data     write port (ignored when full)
//   i_pop              read advance (ignored when empty)
//   o_data             head word (combinational)
//   o_count            occupancy, 0..FIFO_DEPTH
//   o_empty, o_full    status flags
module pix_fifo
  import img_stream_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned FIFO_DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [PIX_W-1:0]   i_data,
  input  logic               i_pop,
  output logic [PIX_W-1:0]   o_data,
  output logic [cnt_w(FIFO_DEPTH):0] o_count,
  output logic               o_empty,
  output logic               o_full
);

  localparam int unsigned FIFO_AW = cnt_w(FIFO_DEPTH);

  logic [PIX_W-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_data    = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (FIFO_AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (FIFO_AW+1)'(1);
    end
  end

  // Storage, no reset needed: contents are only read behind the pointers
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/img_rom_streamer.sv
// Purpose: stream an IMG_W x IMG_H image from a synchronous ROM into a
//   pixel FIFO with nearest-neighbour upscaling (rows re-fetched VSCALE
//   times, each FIFO word presented HSCALE times on the read side).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_vsync           active-low frame restart; low holds everything flushed
//   rom_ce, rom_addr  ROM read request (rom_ce combinational from state/credit)
//   rom_dout          ROM data, valid ROM_LATENCY cycles after rom_ce
//   i_next            consumer takes o_data this cycle
//   o_data, o_valid   FIFO head and not-empty
//   o_frame_done      every pixel of the frame has been fetched
//   o_underflow_cnt   (IMG_ROM_STREAMER_UNDERFLOW_EN only) saturating count
//                     of takes while empty outside S_IDLE
// Build option: define IMG_ROM_STREAMER_UNDERFLOW_EN to add the underflow counter.
module img_rom_streamer
  import img_stream_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned IMG_W       = 225,
  parameter int unsigned IMG_H       = 225,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned BASE_ADDR   = 10,
  parameter int unsigned HSCALE      = 2,
  parameter int unsigned VSCALE      = 2,
  parameter int unsigned ROM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vsync,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_dout,
  input  logic              i_next,
  output logic [PIX_W-1:0]  o_data,
  output logic              o_valid,
  output logic              o_frame_done
`ifdef IMG_ROM_STREAMER_UNDERFLOW_EN
  ,
  output logic [UFLOW_W-1:0] o_underflow_cnt
`endif
);

  localparam int unsigned COL_W   = cnt_w(IMG_W);
  localparam int unsigned ROW_W   = cnt_w(IMG_H);
  localparam int unsigned VPASS_W = cnt_w(VSCALE);
  localparam int unsigned HCNT_W  = cnt_w(HSCALE);
  localparam int unsigned FIFO_AW = cnt_w(FIFO_DEPTH);
  localparam int unsigned INF_W   = cnt_w(ROM_LATENCY + 1);

  state_e               r_state;
  state_e               w_next_state;
  logic                 w_rom_ce;
  logic                 w_clear;
  logic                 w_credit;
  logic                 w_last_col;
  logic                 w_last_row;
  logic                 w_last_vpass;
  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic [VPASS_W-1:0]   r_vpass;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    r_row_base;
  logic [ROM_LATENCY-1:0] r_vpipe;
  logic [INF_W-1:0]     r_inflight;
  logic                 w_tap;
  logic [HCNT_W-1:0]    r_hcnt;
  logic                 w_hlast;
  logic                 w_take;
  logic                 w_pop;
  logic                 r_frame_done;
  logic [PIX_W-1:0]     w_fifo_data;
  logic [FIFO_AW:0]     w_fifo_cnt;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;

  assign w_clear      = !rst_n || !i_vsync;
  assign w_last_col   = (r_col == COL_W'(IMG_W - 1));
  assign w_last_row   = (r_row == ROW_W'(IMG_H - 1));
  assign w_last_vpass = (r_vpass == VPASS_W'(VSCALE - 1));
  // Words already stored plus words still in the ROM pipe never exceed depth
  assign w_credit     = (32'(w_fifo_cnt) + 32'(r_inflight)) < 32'(FIFO_DEPTH);
  assign w_tap        = r_vpipe[ROM_LATENCY-1];

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next state and ROM request
  always_comb begin
    w_next_state = r_state;
    w_rom_ce     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_vsync) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        w_rom_ce = w_credit && !w_fifo_full;
        if (w_rom_ce && w_last_col && w_last_row && w_last_vpass)
          w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (w_clear) begin
      w_next_state = S_IDLE;
      w_rom_ce     = 1'b0;
    end
  end

  assign rom_ce   = w_rom_ce;
  assign rom_addr = r_addr;

  // Incremental address generator; row_base tracks the start of the current row
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_col      <= '0;
      r_row      <= '0;
      r_vpass    <= '0;
      r_addr     <= ADDR_W'(BASE_ADDR);
      r_row_base <= ADDR_W'(BASE_ADDR);
    end else if (w_rom_ce) begin
      if (!w_last_col) begin
        r_col  <= r_col + COL_W'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end else begin
        r_col <= '0;
        if (!w_last_vpass) begin
          r_vpass <= r_vpass + VPASS_W'(1);
          r_addr  <= r_row_base;
        end else begin
          r_vpass    <= '0;
          r_row      <= r_row + ROW_W'(1);
          r_row_base <= r_row_base + ADDR_W'(IMG_W);
          r_addr     <= r_row_base + ADDR_W'(IMG_W);
        end
      end
    end
  end

  // Valid pipe mirrors ROM latency; clearing it squashes in-flight returns
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_vpipe    <= '0;
      r_inflight <= '0;
    end else begin
      r_vpipe[0] <= w_rom_ce;
      for (int i = 1; i < ROM_LATENCY; i++) r_vpipe[i] <= r_vpipe[i-1];
      r_inflight <= r_inflight + INF_W'(w_rom_ce) - INF_W'(w_tap);
    end
  end

  // Horizontal repeat: each FIFO word is taken HSCALE times before popping
  assign w_take  = i_next && o_valid;
  assign w_hlast = (r_hcnt == HCNT_W'(HSCALE - 1));
  assign w_pop   = w_take && w_hlast;

  always_ff @(posedge clk) begin
    if (w_clear)     r_hcnt <= '0;
    else if (w_take) r_hcnt <= w_hlast ? '0 : (r_hcnt + HCNT_W'(1));
  end

  // Frame done flag
  always_ff @(posedge clk) begin
    if (w_clear) r_frame_done <= 1'b0;
    else         r_frame_done <= (w_next_state == S_DONE);
  end

  assign o_frame_done = r_frame_done;
  assign o_valid      = !w_fifo_empty;
  assign o_data       = w_fifo_data;

  pix_fifo #(
    .PIX_W      (PIX_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (!i_vsync),
    .i_push  (w_tap),
    .i_data  (rom_dout),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_cnt),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

`ifdef IMG_ROM_STREAMER_UNDERFLOW_EN
  logic [UFLOW_W-1:0] r_uflow;

  // Saturating count of takes while empty outside S_IDLE
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_uflow <= '0;
    end else if (i_next && !o_valid && (r_state != S_IDLE) &&
                 (r_uflow != {UFLOW_W{1'b1}})) begin
      r_uflow <= r_uflow + UFLOW_W'(1);
    end
  end

  assign o_underflow_cnt = r_uflow;
`endif

endmodule

// File: tb/tb_img_rom_streamer.sv
module tb_img_rom_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Instance A: nominal geometry, 2x2, latency 2, depth 4
  logic        a_vsync, a_next, a_ce, a_valid, a_fd;
  logic [15:0] a_addr;
  logic [7:0]  a_dout, a_data;
  // Instance B: same geometry, latency 3, depth 8
  logic        b_vsync, b_next, b_ce, b_valid, b_fd;
  logic [15:0] b_addr;
  logic [7:0]  b_dout, b_data;
  // Instance C: no scaling, latency 2, depth 4
  logic        c_vsync, c_next, c_ce, c_valid, c_fd;
  logic [15:0] c_addr;
  logic [7:0]  c_dout, c_data;
`ifdef IMG_ROM_STREAMER_UNDERFLOW_EN
  logic [15:0] a_uflow, b_uflow, c_uflow;
`endif

  img_rom_streamer #(.PIX_W(8), .IMG_W(4), .IMG_H(2), .ADDR_W(16), .BASE_ADDR(10),
    .HSCALE(2), .VSCALE(2), .ROM_LATENCY(2), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .i_vsync(a_vsync), .rom_ce(a_ce), .rom_addr(a_addr),
    .rom_dout(a_dout), .i_next(a_next), .o_data(a_data), .o_valid(a_valid),
    .o_frame_done(a_fd)
`ifdef IMG_ROM_STREAMER_UNDERFLOW_EN
    , .o_underflow_cnt(a_uflow)
`endif
  );

  img_rom_streamer #(.PIX_W(8), .IMG_W(4), .IMG_H(2), .ADDR_W(16), .BASE_ADDR(10),
    .HSCALE(2), .VSCALE(2), .ROM_LATENCY(3), .FIFO_DEPTH(8)) u_b (
    .clk(clk), .rst_n(rst_n), .i_vsync(b_vsync), .rom_ce(b_ce), .rom_addr(b_addr),
    .rom_dout(b_dout), .i_next(b_next), .o_data(b_data), .o_valid(b_valid),
    .o_frame_done(b_fd)
`ifdef IMG_ROM_STREAMER_UNDERFLOW_EN
    , .o_underflow_cnt(b_uflow)
`endif
  );

  img_rom_streamer #(.PIX_W(8), .IMG_W(4), .IMG_H(2), .ADDR_W(16), .BASE_ADDR(10),
    .HSCALE(1), .VSCALE(1), .ROM_LATENCY(2), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .i_vsync(c_vsync), .rom_ce(c_ce), .rom_addr(c_addr),
    .rom_dout(c_dout), .i_next(c_next), .o_data(c_data), .o_valid(c_valid),
    .o_frame_done(c_fd)
`ifdef IMG_ROM_STREAMER_UNDERFLOW_EN
    , .o_underflow_cnt(c_uflow)
`endif
  );

  // ROM models: ROM[a] = a, data only meaningful when the request was real
  logic [15:0] a_ap [0:1];
  logic [1:0]  a_vp = '0;
  logic [15:0] b_ap [0:2];
  logic [2:0]  b_vp = '0;
  logic [15:0] c_ap [0:1];
  logic [1:0]  c_vp = '0;

  always @(posedge clk) begin
    a_ap[0] <= a_addr; a_ap[1] <= a_ap[0]; a_vp <= {a_vp[0], a_ce};
    b_ap[0] <= b_addr; b_ap[1] <= b_ap[0]; b_ap[2] <= b_ap[1]; b_vp <= {b_vp[1:0], b_ce};
    c_ap[0] <= c_addr; c_ap[1] <= c_ap[0]; c_vp <= {c_vp[0], c_ce};
  end

  assign a_dout = a_vp[1] ? a_ap[1][7:0] : 8'hEE;
  assign b_dout = b_vp[2] ? b_ap[2][7:0] : 8'hEE;
  assign c_dout = c_vp[1] ? c_ap[1][7:0] : 8'hEE;

  // Output capture at the negedge: a take here is consumed at the next posedge
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  logic [7:0] q_c [$];
  int         b_rises = 0;
  logic       b_fd_prev = 1'b0;

  always @(negedge clk) begin
    if (a_next && a_valid) q_a.push_back(a_data);
    if (b_next && b_valid) q_b.push_back(b_data);
    if (c_next && c_valid) q_c.push_back(c_data);
    if (b_fd && !b_fd_prev) b_rises++;
    b_fd_prev = b_fd;
  end

  logic [7:0] exp_nom [32];
  logic [7:0] exp_x1  [8];

  task automatic test_reset();
    rst_n = 1'b0;
    a_vsync = 1'b0; a_next = 1'b0;
    b_vsync = 1'b0; b_next = 1'b0;
    c_vsync = 1'b0; c_next = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (a_ce !== 1'b0) begin errors++; $display("FAIL reset_rom_ce got %b want 0", a_ce); end
    checks++; if (a_addr !== 16'd10) begin errors++; $display("FAIL reset_rom_addr got %0d want 10", a_addr); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b want 0", a_valid); end
    checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", a_fd); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    logic [7:0] v;
    a_vsync = 1'b0; a_next = 1'b0;
    repeat (2) @(posedge clk); #1;
    q_a.delete();
    a_vsync = 1'b1; a_next = 1'b1;
    for (int n = 0; n < 400 && q_a.size() < 32; n++) @(posedge clk);
    @(negedge clk);
    checks++; if (q_a.size() != 32) begin errors++; $display("FAIL nominal_count got %0d want 32", q_a.size()); end
    for (int i = 0; i < 32; i++) begin
      v = (i < q_a.size()) ? q_a[i] : 8'hXX;
      checks++; if (v !== exp_nom[i]) begin errors++; $display("FAIL nominal_pix[%0d] got %0d want %0d", i, v, exp_nom[i]); end
    end
    checks++; if (a_fd !== 1'b1) begin errors++; $display("FAIL nominal_frame_done got %b want 1", a_fd); end
    checks++; if (a_ce !== 1'b0) begin errors++; $display("FAIL nominal_done_rom_ce got %b want 0", a_ce); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL nominal_drained got %b want 0", a_valid); end
    a_next = 1'b0; a_vsync = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] v;
    a_vsync = 1'b0; a_next = 1'b0;
    repeat (2) @(posedge clk); #1;
    q_a.delete();
    a_vsync = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++; if (u_a.w_fifo_cnt !== 3'd4) begin errors++; $display("FAIL bp_fifo_cnt got %0d want 4", u_a.w_fifo_cnt); end
    checks++; if (a_ce !== 1'b0) begin errors++; $display("FAIL bp_rom_ce got %b want 0", a_ce); end
    checks++; if (a_addr !== 16'd10) begin errors++; $display("FAIL bp_rom_addr got %0d want 10", a_addr); end
    checks++; if (a_valid !== 1'b1 || a_data !== 8'd10) begin errors++; $display("FAIL bp_head got v=%b d=%0d want v=1 d=10", a_valid, a_data); end
    @(posedge clk); #1;
    a_next = 1'b1;
    for (int n = 0; n < 400 && q_a.size() < 32; n++) @(posedge clk);
    @(negedge clk);
    checks++; if (q_a.size() != 32) begin errors++; $display("FAIL bp_count got %0d want 32", q_a.size()); end
    for (int i = 0; i < 32; i++) begin
      v = (i < q_a.size()) ? q_a[i] : 8'hXX;
      checks++; if (v !== exp_nom[i]) begin errors++; $display("FAIL bp_pix[%0d] got %0d want %0d", i, v, exp_nom[i]); end
    end
    a_next = 1'b0; a_vsync = 1'b0;
  endtask

  task automatic test_vsync_mid();
    logic [7:0] v;
    int         n;
    a_vsync = 1'b0; a_next = 1'b0;
    repeat (2) @(posedge clk); #1;
    q_a.delete();
    a_vsync = 1'b1; a_next = 1'b1;
    for (n = 0; n < 200 && q_a.size() < 7; n++) @(posedge clk);
    #1;
    v = (q_a.size() >= 7) ? q_a[6] : 8'hXX;
    checks++; if (v !== 8'd13) begin errors++; $display("FAIL vs_pre_pix got %0d want 13", v); end
    a_next = 1'b0; a_vsync = 1'b0;
    @(posedge clk); #1;
    a_vsync = 1'b1;
    @(negedge clk);
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL vs_o_valid got %b want 0", a_valid); end
    checks++; if (a_addr !== 16'd10) begin errors++; $display("FAIL vs_rom_addr got %0d want 10", a_addr); end
    checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL vs_frame_done got %b want 0", a_fd); end
    q_a.delete();
    a_next = 1'b1;
    for (n = 0; n < 400 && q_a.size() < 32; n++) @(posedge clk);
    @(negedge clk);
    checks++; if (q_a.size() != 32) begin errors++; $display("FAIL vs_count got %0d want 32", q_a.size()); end
    for (int i = 0; i < 32; i++) begin
      v = (i < q_a.size()) ? q_a[i] : 8'hXX;
      checks++; if (v !== exp_nom[i]) begin errors++; $display("FAIL vs_pix[%0d] got %0d want %0d", i, v, exp_nom[i]); end
    end
    a_next = 1'b0; a_vsync = 1'b0;
  endtask

  task automatic test_underflow();
    logic [7:0] v;
    a_vsync = 1'b0; a_next = 1'b1;
    repeat (2) @(posedge clk); #1;
`ifdef IMG_ROM_STREAMER_UNDERFLOW_EN
    checks++; if (a_uflow !== 16'd0) begin errors++; $display("FAIL uf_cleared got %0d want 0", a_uflow); end
`endif
    q_a.delete();
    a_vsync = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL uf_empty got %b want 0", a_valid); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_valid !== 1'b1 || a_data !== 8'd10) begin errors++; $display("FAIL uf_first got v=%b d=%0d want v=1 d=10", a_valid, a_data); end
    repeat (6) @(posedge clk);
    @(negedge clk);
`ifdef IMG_ROM_STREAMER_UNDERFLOW_EN
    checks++; if (a_uflow !== 16'd3) begin errors++; $display("FAIL uf_count got %0d want 3", a_uflow); end
`endif
    for (int n = 0; n < 400 && q_a.size() < 32; n++) @(posedge clk);
    @(negedge clk);
    checks++; if (q_a.size() != 32) begin errors++; $display("FAIL uf_len got %0d want 32", q_a.size()); end
    for (int i = 0; i < 32; i++) begin
      v = (i < q_a.size()) ? q_a[i] : 8'hXX;
      checks++; if (v !== exp_nom[i]) begin errors++; $display("FAIL uf_pix[%0d] got %0d want %0d", i, v, exp_nom[i]); end
    end
    a_next = 1'b0; a_vsync = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    c_vsync = 1'b0; c_next = 1'b0;
    repeat (2) @(posedge clk); #1;
    c_vsync = 1'b1; c_next = 1'b1;
    repeat (5) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_c.delete();
    @(negedge clk);
    checks++; if (c_ce !== 1'b0) begin errors++; $display("FAIL rm_rom_ce got %b want 0", c_ce); end
    checks++; if (c_addr !== 16'd10) begin errors++; $display("FAIL rm_rom_addr got %0d want 10", c_addr); end
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL rm_o_valid got %b want 0", c_valid); end
    checks++; if (c_fd !== 1'b0) begin errors++; $display("FAIL rm_frame_done got %b want 0", c_fd); end
    for (int n = 0; n < 200 && q_c.size() < 8; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (q_c.size() != 8) begin errors++; $display("FAIL rm_count got %0d want 8", q_c.size()); end
    for (int i = 0; i < 8; i++) begin
      v = (i < q_c.size()) ? q_c[i] : 8'hXX;
      checks++; if (v !== exp_x1[i]) begin errors++; $display("FAIL rm_pix[%0d] got %0d want %0d", i, v, exp_x1[i]); end
    end
    checks++; if (c_fd !== 1'b1) begin errors++; $display("FAIL rm_done got %b want 1", c_fd); end
    c_next = 1'b0; c_vsync = 1'b0;
  endtask

  task automatic test_latency3();
    logic [7:0] v;
    b_vsync = 1'b0; b_next = 1'b0;
    repeat (2) @(posedge clk); #1;
    q_b.delete();
    b_rises = 0;
    b_vsync = 1'b1; b_next = 1'b1;
    for (int n = 0; n < 500 && q_b.size() < 32; n++) @(posedge clk);
    @(negedge clk);
    checks++; if (q_b.size() != 32) begin errors++; $display("FAIL l3_count got %0d want 32", q_b.size()); end
    for (int i = 0; i < 32; i++) begin
      v = (i < q_b.size()) ? q_b[i] : 8'hXX;
      checks++; if (v !== exp_nom[i]) begin errors++; $display("FAIL l3_pix[%0d] got %0d want %0d", i, v, exp_nom[i]); end
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (b_fd !== 1'b1) begin errors++; $display("FAIL l3_done_hold got %b want 1", b_fd); end
    checks++; if (b_rises != 1) begin errors++; $display("FAIL l3_done_rises got %0d want 1", b_rises); end
    checks++; if (b_ce !== 1'b0) begin errors++; $display("FAIL l3_done_rom_ce got %b want 0", b_ce); end
    b_vsync = 1'b0; b_next = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (b_fd !== 1'b0) begin errors++; $display("FAIL l3_done_clear got %b want 0", b_fd); end
  endtask

  initial begin
    int k;
    k = 0;
    for (int r = 0; r < 2; r++)
      for (int vp = 0; vp < 2; vp++)
        for (int c = 0; c < 4; c++)
          for (int h = 0; h < 2; h++) begin
            exp_nom[k] = 8'(10 + 4 * r + c);
            k++;
          end
    for (int i = 0; i < 8; i++) exp_x1[i] = 8'(10 + i);

    test_reset();
    test_nominal();
    test_backpressure();
    test_vsync_mid();
    test_underflow();
    test_reset_mid();
    test_latency3();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
